trg_debounce_oneshot: RTL

Trigger conditioning stage that sits directly upstream of the one-shot/periodic timer and drives its TRG_ONE input. It synchronises a raw asynchronous push-switch level, debounces press and release with a cycle counter, and emits a single-cycle TRG_ONE pulse per accepted press. An optional hold-to-repeat mode re-issues the pulse periodically while the switch stays held. A debounced level output is provided for status use.

---
 rtl/trg_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/trg_debounce_oneshot.sv | 138 +++++++++++++
 3 files changed

// File: rtl/trg_pkg.sv
// -----------------------------------------------------------------------------
// trg_pkg
// Shared definitions for the trigger conditioning stage.
//   trg_state_e    : debounce FSM state encoding (2 bits)
//   DB_N_DEFAULT   : default number of stable cycles to accept press/release
//   REP_N_DEFAULT  : default hold-to-repeat period in cycles
// -----------------------------------------------------------------------------
package trg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } trg_state_e;

    localparam logic [15:0] DB_N_DEFAULT  = 16'd50000;
    localparam logic [15:0] REP_N_DEFAULT = 16'd60000;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop level synchroniser for a single asynchronous input.
//   CLK : destination clock, rising edge
//   R_N : asynchronous active-low reset, both flops clear to 0
//   D   : asynchronous level in
//   Q   : synchronised level out (second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic CLK,
    input  logic R_N,
    input  logic D,
    output logic Q
);

    logic meta_r;
    logic q_r;

    // Synchroniser chain; the first flop may go metastable, the second filters it.
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= D;
            q_r    <= meta_r;
        end
    end

    assign Q = q_r;

endmodule

// File: rtl/trg_debounce_oneshot.sv
// -----------------------------------------------------------------------------
// trg_debounce_oneshot
// Conditions a raw push-switch level into a single-cycle trigger pulse for the
// downstream timer. The level is synchronised, press and release are each
// debounced over DB_N consecutive stable cycles, and an accepted press emits
// one TRG_ONE pulse. With REP_EN=1 the pulse repeats every REP_N cycles while
// the switch stays held.
//   CLK       : system clock, rising edge
//   R_N       : asynchronous active-low reset
//   SW_IN     : raw switch level (async), 1 = pressed
//   EN        : trigger enable, gates TRG_ONE only
//   TRG_ONE   : registered one-cycle trigger pulse
//   SW_STABLE : registered debounced switch level
// -----------------------------------------------------------------------------
module trg_debounce_oneshot
    import trg_pkg::*;
#(
    parameter int unsigned   BW     = 16,
    parameter logic [BW-1:0] DB_N   = BW'(DB_N_DEFAULT),
    parameter logic          REP_EN = 1'b0,
    parameter logic [BW-1:0] REP_N  = BW'(REP_N_DEFAULT)
) (
    input  logic CLK,
    input  logic R_N,
    input  logic SW_IN,
    input  logic EN,
    output logic TRG_ONE,
    output logic SW_STABLE
);

    localparam logic [BW-1:0] CNT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] CNT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    // Terminal counts: the counter is cleared on every state entry, so
    // reaching N-1 means N consecutive qualifying cycles have elapsed.
    localparam logic [BW-1:0] DB_LAST  = DB_N - CNT_ONE;
    localparam logic [BW-1:0] REP_LAST = REP_N - CNT_ONE;

    logic       sw_s;
    trg_state_e state_r;
    trg_state_e state_s;
    logic [BW-1:0] cnt_r;
    logic [BW-1:0] cnt_s;
    logic       trg_r;
    logic       trg_s;
    logic       stable_r;
    logic       stable_s;

    sync_2ff u_sync_sw (
        .CLK (CLK),
        .R_N (R_N),
        .D   (SW_IN),
        .Q   (sw_s)
    );

    // Next-state, shared counter and output decode for the debounce FSM.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        trg_s    = 1'b0;
        stable_s = stable_r;
        case (state_r)
            IDLE: begin
                if (sw_s) begin
                    state_s = PRESS_CHK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            PRESS_CHK: begin
                if (!sw_s) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_s  = HELD;
                    cnt_s    = CNT_ZERO;
                    stable_s = 1'b1;
                    trg_s    = EN;
                end else begin
                    cnt_s    = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (!sw_s) begin
                    state_s = REL_CHK;
                    cnt_s   = CNT_ZERO;
                end else if (REP_EN && (cnt_r == REP_LAST)) begin
                    cnt_s   = CNT_ZERO;
                    trg_s   = EN;
                end else if (REP_EN) begin
                    cnt_s   = cnt_r + CNT_ONE;
                end else begin
                    // No repeat: keep the counter parked so a later bounce
                    // back from REL_CHK starts from a known value.
                    cnt_s   = CNT_ZERO;
                end
            end
            REL_CHK: begin
                if (sw_s) begin
                    // Short release glitch: back to HELD, repeat period restarts,
                    // no new pulse.
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_s  = IDLE;
                    cnt_s    = CNT_ZERO;
                    stable_s = 1'b0;
                end else begin
                    cnt_s    = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s  = IDLE;
                cnt_s    = CNT_ZERO;
                stable_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            trg_r    <= 1'b0;
            stable_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            trg_r    <= trg_s;
            stable_r <= stable_s;
        end
    end

    assign TRG_ONE   = trg_r;
    assign SW_STABLE = stable_r;

endmodule
